// File: rtl/mole_round_scheduler_if.sv
// Game-side signal bundle of the whack-a-mole round scheduler.
// The master side drives the player inputs; the slave is the scheduler.
interface mole_round_scheduler_if;
  logic        tick_i;
  logic        start_i;
  logic [1:0]  mode_i;
  logic [15:0] switches_i;
  logic [15:0] LEDs_o;
  logic        whack_o;
  logic [15:0] score_o;
  logic [7:0]  miss_o;
  logic [6:0]  time_left_o;
  logic [1:0]  state_o;

  modport master (
    output tick_i, start_i, mode_i, switches_i,
    input  LEDs_o, whack_o, score_o, miss_o, time_left_o, state_o
  );

  modport slave (
    input  tick_i, start_i, mode_i, switches_i,
    output LEDs_o, whack_o, score_o, miss_o, time_left_o, state_o
  );
endinterface

// File: rtl/mole_round_scheduler.sv
// Round controller for whack-a-mole: phases, LFSR mole placement,
// mole lifetime/gap timing per difficulty, whack and miss scoring.
module mole_round_scheduler #(
  parameter int unsigned ROUND_SECS = 30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic clock_i,
  input logic reset_i,
  mole_round_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, COUNTDOWN = 2'b01, PLAY = 2'b10, DONE = 2'b11} phase_t;
  typedef enum logic {GAP = 1'b0, UP = 1'b1} mole_t;

  localparam logic [6:0] ROUND_TL = 7'(ROUND_SECS);

  phase_t      phase_q, phase_d;
  mole_t       mole_q, mole_d;
  logic [15:0] lfsr_q, lfsr_d, prev_sw_q, leds_q, leds_d, score_q, score_d;
  logic [1:0]  mode_q, mode_d, quarter_q, quarter_d, gap_q, gap_d, gap_len;
  logic [7:0]  miss_q, miss_d;
  logic [6:0]  time_q, time_d;
  logic [3:0]  life_q, life_d, pos_q, pos_d, cand, life_len;
  logic        whack_q, whack_d, hit, round_wrap, final_tick;

  always_comb begin
    unique case (mode_q)
      2'b01:   begin life_len = 4'd8; gap_len = 2'd2; end
      2'b10:   begin life_len = 4'd4; gap_len = 2'd1; end
      default: begin life_len = 4'd2; gap_len = 2'd1; end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      phase_q   <= IDLE;
      mole_q    <= GAP;
      lfsr_q    <= LFSR_SEED;
      prev_sw_q <= bus.switches_i;
      leds_q    <= '0;
      score_q   <= '0;
      miss_q    <= '0;
      time_q    <= '0;
      mode_q    <= 2'b00;
      quarter_q <= '0;
      life_q    <= '0;
      gap_q     <= '0;
      pos_q     <= '0;
      whack_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      mole_q    <= mole_d;
      lfsr_q    <= lfsr_d;
      prev_sw_q <= bus.switches_i;
      leds_q    <= leds_d;
      score_q   <= score_d;
      miss_q    <= miss_d;
      time_q    <= time_d;
      mode_q    <= mode_d;
      quarter_q <= quarter_d;
      life_q    <= life_d;
      gap_q     <= gap_d;
      pos_q     <= pos_d;
      whack_q   <= whack_d;
    end
  end

  // A whack beats an expiry on the same tick; the final round tick ends
  // the round without counting a miss for a mole still lit.
  always_comb begin
    phase_d    = phase_q;
    mole_d     = mole_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    leds_d     = leds_q;
    score_d    = score_q;
    miss_d     = miss_q;
    time_d     = time_q;
    mode_d     = mode_q;
    quarter_d  = quarter_q;
    life_d     = life_q;
    gap_d      = gap_q;
    pos_d      = pos_q;
    whack_d    = 1'b0;
    cand       = (lfsr_q[3:0] == pos_q) ? lfsr_q[3:0] + 4'd1 : lfsr_q[3:0];
    hit        = (mole_q == UP) && (bus.switches_i[pos_q] != prev_sw_q[pos_q]);
    round_wrap = bus.tick_i && (quarter_q == 2'd3);
    final_tick = round_wrap && (time_q == 7'd1);

    unique case (phase_q)
      IDLE: begin
        if (bus.start_i && (bus.mode_i != 2'b00)) begin
          mode_d    = bus.mode_i;
          score_d   = '0;
          miss_d    = '0;
          time_d    = 7'd3;
          quarter_d = '0;
          phase_d   = COUNTDOWN;
        end
      end
      DONE: begin
        if (bus.start_i) begin
          score_d   = '0;
          miss_d    = '0;
          time_d    = 7'd3;
          quarter_d = '0;
          phase_d   = COUNTDOWN;
        end
      end
      COUNTDOWN: begin
        if (bus.tick_i) quarter_d = quarter_q + 2'd1;
        if (round_wrap) begin
          if (time_q == 7'd1) begin
            time_d    = ROUND_TL;
            quarter_d = '0;
            phase_d   = PLAY;
            mole_d    = GAP;
            gap_d     = 2'd1;
          end else begin
            time_d = time_q - 7'd1;
          end
        end
      end
      PLAY: begin
        if (bus.tick_i) quarter_d = quarter_q + 2'd1;
        if (round_wrap && (time_q != 7'd0)) time_d = time_q - 7'd1;
        if (hit) begin
          score_d = (score_q == 16'd9999) ? score_q : score_q + 16'd1;
          whack_d = 1'b1;
          leds_d  = '0;
          mole_d  = GAP;
          gap_d   = gap_len;
        end
        if (final_tick) begin
          leds_d  = '0;
          phase_d = DONE;
        end else if (bus.tick_i && !hit) begin
          if (mole_q == GAP) begin
            if (gap_q <= 2'd1) begin
              pos_d  = cand;
              leds_d = 16'd1 << cand;
              life_d = life_len;
              mole_d = UP;
            end else begin
              gap_d = gap_q - 2'd1;
            end
          end else if (life_q <= 4'd1) begin
            miss_d = (miss_q == 8'd255) ? miss_q : miss_q + 8'd1;
            leds_d = '0;
            mole_d = GAP;
            gap_d  = gap_len;
          end else begin
            life_d = life_q - 4'd1;
          end
        end
      end
    endcase
  end

  assign bus.LEDs_o      = leds_q;
  assign bus.whack_o     = whack_q;
  assign bus.score_o     = score_q;
  assign bus.miss_o      = miss_q;
  assign bus.time_left_o = time_q;
  assign bus.state_o     = phase_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler with a 3-second round.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mole_round_scheduler;

  logic clock_i = 1'b0;
  logic reset_i;
  int   total;
  int   bad;
  logic sawWhack;
  logic [15:0] lit;
  logic [15:0] prevLit;
  logic [15:0] other;

  mole_round_scheduler_if bus ();

  mole_round_scheduler #(.ROUND_SECS(3), .LFSR_SEED(16'hACE1)) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .bus(bus)
  );

  always #5 clock_i = ~clock_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given tick/start and a set of switch bits flipped.
  task automatic applyStimulus(input logic tick, input logic start, input logic [15:0] flip);
    bus.tick_i     = tick;
    bus.start_i    = start;
    bus.switches_i = bus.switches_i ^ flip;
    @(posedge clock_i);
    #1;
    bus.tick_i  = 1'b0;
    bus.start_i = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset_i        = 1'b1;
    bus.tick_i     = 1'b0;
    bus.start_i    = 1'b0;
    bus.mode_i     = 2'b00;
    bus.switches_i = 16'($urandom);
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    reset_i  = 1'b0;
    sawWhack = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0);
      if (bus.whack_o) sawWhack = 1'b1;
    end
    checkOutput("idleLeds", 32'(bus.LEDs_o), 0);
    checkOutput("idleWhack", 32'(sawWhack), 0);
    checkOutput("idleScore", 32'(bus.score_o), 0);
    checkOutput("idleMiss", 32'(bus.miss_o), 0);
    checkOutput("idleTime", 32'(bus.time_left_o), 0);
    checkOutput("idleState", 32'(bus.state_o), 0);

    applyStimulus(1'b0, 1'b1, 16'h0);
    checkOutput("startNoMode", 32'(bus.state_o), 0);

    bus.mode_i = 2'b11;
    applyStimulus(1'b0, 1'b1, 16'h0);
    checkOutput("startState", 32'(bus.state_o), 1);
    checkOutput("startTime", 32'(bus.time_left_o), 3);
    bus.mode_i = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      if (i == 4) checkOutput("cdTime2", 32'(bus.time_left_o), 2);
      if (i == 5) begin
        applyStimulus(1'b0, 1'b1, 16'h0);
        checkOutput("cdStartIgnState", 32'(bus.state_o), 1);
        checkOutput("cdStartIgnTime", 32'(bus.time_left_o), 2);
      end
      if (i == 8) checkOutput("cdTime1", 32'(bus.time_left_o), 1);
      if (i == 11) checkOutput("cdStill", 32'(bus.state_o), 1);
    end
    checkOutput("playState", 32'(bus.state_o), 2);
    checkOutput("playTime", 32'(bus.time_left_o), 3);
    checkOutput("playLedsOff", 32'(bus.LEDs_o), 0);

    // Hard round: 12 play ticks
    applyStimulus(1'b1, 1'b0, 16'h0);
    lit = bus.LEDs_o;
    checkOutput("hardSpawn", 32'($onehot(lit)), 1);
    applyStimulus(1'b0, 1'b0, lit);
    checkOutput("whackLeds", 32'(bus.LEDs_o), 0);
    checkOutput("whackPulse", 32'(bus.whack_o), 1);
    checkOutput("whackScore", 32'(bus.score_o), 1);
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("whackOneCycle", 32'(bus.whack_o), 0);

    applyStimulus(1'b1, 1'b0, 16'h0);
    lit   = bus.LEDs_o;
    other = (lit == 16'h0001) ? 16'h0002 : 16'h0001;
    applyStimulus(1'b0, 1'b0, other);
    checkOutput("unlitLeds", 32'(bus.LEDs_o), 32'(lit));
    checkOutput("unlitScore", 32'(bus.score_o), 1);
    checkOutput("unlitWhack", 32'(bus.whack_o), 0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("hardStillUp", 32'(bus.LEDs_o), 32'(lit));
    applyStimulus(1'b1, 1'b0, lit);
    checkOutput("tieScore", 32'(bus.score_o), 2);
    checkOutput("tieMiss", 32'(bus.miss_o), 0);
    checkOutput("tieLeds", 32'(bus.LEDs_o), 0);
    checkOutput("playTime2", 32'(bus.time_left_o), 2);

    for (int i = 5; i <= 7; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("expireMiss", 32'(bus.miss_o), 1);
    checkOutput("expireLeds", 32'(bus.LEDs_o), 0);
    for (int i = 8; i <= 10; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("expireMiss2", 32'(bus.miss_o), 2);
    applyStimulus(1'b1, 1'b0, 16'h0);
    lit = bus.LEDs_o;
    applyStimulus(1'b1, 1'b0, lit);
    checkOutput("finalScore", 32'(bus.score_o), 3);
    checkOutput("finalMiss", 32'(bus.miss_o), 2);
    checkOutput("finalState", 32'(bus.state_o), 3);
    checkOutput("finalLeds", 32'(bus.LEDs_o), 0);
    checkOutput("finalTime", 32'(bus.time_left_o), 0);
    checkOutput("finalWhack", 32'(bus.whack_o), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("doneHoldScore", 32'(bus.score_o), 3);
    checkOutput("doneHoldState", 32'(bus.state_o), 3);

    // Restart from DONE keeps the latched hard mode
    applyStimulus(1'b0, 1'b1, 16'h0);
    checkOutput("restartState", 32'(bus.state_o), 1);
    checkOutput("restartScore", 32'(bus.score_o), 0);
    checkOutput("restartMiss", 32'(bus.miss_o), 0);
    checkOutput("restartTime", 32'(bus.time_left_o), 3);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("reuseModeMiss", 32'(bus.miss_o), 1);
    checkOutput("reuseModeLeds", 32'(bus.LEDs_o), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, bus.LEDs_o);
    end
    checkOutput("fiveScore", 32'(bus.score_o), 5);
    reset_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0);
    reset_i = 1'b0;
    checkOutput("rstLeds", 32'(bus.LEDs_o), 0);
    checkOutput("rstWhack", 32'(bus.whack_o), 0);
    checkOutput("rstScore", 32'(bus.score_o), 0);
    checkOutput("rstMiss", 32'(bus.miss_o), 0);
    checkOutput("rstTime", 32'(bus.time_left_o), 0);
    checkOutput("rstState", 32'(bus.state_o), 0);

    // Easy round with no switch activity
    bus.mode_i = 2'b01;
    applyStimulus(1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("easyPlay", 32'(bus.state_o), 2);
    applyStimulus(1'b1, 1'b0, 16'h0);
    lit = bus.LEDs_o;
    checkOutput("easySpawn", 32'($onehot(lit)), 1);
    for (int i = 2; i <= 8; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("easyLife8", 32'(bus.LEDs_o), 32'(lit));
    checkOutput("easyNoMissYet", 32'(bus.miss_o), 0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("easyExpireLeds", 32'(bus.LEDs_o), 0);
    checkOutput("easyExpireMiss", 32'(bus.miss_o), 1);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("easyGap", 32'(bus.LEDs_o), 0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("easyRespawn", 32'($onehot(bus.LEDs_o)), 1);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("easyDoneState", 32'(bus.state_o), 3);
    checkOutput("easyDoneLeds", 32'(bus.LEDs_o), 0);
    checkOutput("easyDoneMiss", 32'(bus.miss_o), 1);
    checkOutput("easyDoneScore", 32'(bus.score_o), 0);

    // Hard rounds whacking every mole: consecutive positions must differ
    reset_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0);
    reset_i    = 1'b0;
    bus.mode_i = 2'b11;
    for (int r = 0; r < 20; r++) begin
      applyStimulus(1'b0, 1'b1, 16'h0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 16'h0);
      prevLit = 16'h0;
      for (int k = 0; k < 11; k++) begin
        applyStimulus(1'b1, 1'b0, 16'h0);
        lit = bus.LEDs_o;
        if (k > 0) checkOutput("noRepeat", 32'(lit != prevLit), 1);
        prevLit = lit;
        applyStimulus(1'b0, 1'b0, lit);
      end
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("loopDone", 32'(bus.state_o), 3);
      checkOutput("loopScore", 32'(bus.score_o), 11);
    end

    // Score saturation
    applyStimulus(1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    force dut.score_q = 16'd9998;
    applyStimulus(1'b0, 1'b0, 16'h0);
    release dut.score_q;
    applyStimulus(1'b0, 1'b0, bus.LEDs_o);
    checkOutput("satReach", 32'(bus.score_o), 9999);
    applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, bus.LEDs_o);
    checkOutput("satHold", 32'(bus.score_o), 9999);
    checkOutput("satWhack", 32'(bus.whack_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mole_round_scheduler.md
# mole_round_scheduler

Central round controller for the whack-a-mole game. It sequences a round through idle, countdown, play and result phases, picks which mole LED lights next using an LFSR, times each mole's lifetime by difficulty, and judges switch toggles as whacks or misses. It drives the mole LEDs and exposes score, miss count, time left and phase to the display path.

## Interface
Parameters:
- ROUND_SECS, 30: play-phase length in seconds (1..99).
- LFSR_SEED, 16'hACE1: LFSR value loaded on reset; must be non-zero.

Ports:
- clock_i  in  1  system clock. Single clock domain; all state is on its rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- tick_i  in  1  one-cycle pulse at 4 Hz. This is the 250 ms quantum; it is produced upstream by divider edge detection.
- start_i  in  1  one-cycle start pulse from the debounced button.
- mode_i  in  2  difficulty. 00 = none, 01 = easy, 10 = medium, 11 = hard.
- switches_i  in  16  player switches, already synchronised.
- LEDs_o  out  16  active mole, one-hot, or all zero.
- whack_o  out  1  one-cycle pulse on each successful whack.
- score_o  out  16  hits this round, binary, saturates at 9999.
- miss_o  out  8  expired moles this round, saturates at 255.
- time_left_o  out  7  seconds remaining. Shows 3/2/1 during countdown.
- state_o  out  2  phase. 00 = IDLE, 01 = COUNTDOWN, 10 = PLAY, 11 = DONE.

## Operation
Reset values: all outputs 0, state IDLE, LFSR = LFSR_SEED, mode register = 00, previous switches = switches_i.

Top-level FSM:
- IDLE: on start_i with mode_i != 00:
  - latch mode_i;
  - clear score and miss;
  - load time_left = 3 and quarter-tick counter q = 0;
  - go to COUNTDOWN.
  - start_i with mode_i = 00 is ignored.
- COUNTDOWN: q counts tick_i modulo 4. When q wraps, time_left decrements. The tick that would take time_left from 1 to 0 instead:
  - loads time_left = ROUND_SECS and q = 0;
  - enters PLAY in sub-state GAP with gap counter = 1.
- PLAY: time_left decrements every 4th tick. The tick that makes time_left 0:
  - clears LEDs_o;
  - goes to DONE.
- DONE: score, miss and time_left hold. On start_i:
  - clear score and miss;
  - reuse the latched mode;
  - enter COUNTDOWN as from IDLE.
- start_i is ignored in COUNTDOWN and PLAY.

PLAY sub-FSM (counters count tick_i only):

Lifetime and gap per mode:
- easy: lifetime 8 ticks, gap 2 ticks.
- medium: lifetime 4 ticks, gap 1 tick.
- hard: lifetime 2 ticks, gap 1 tick.

Sub-states:
- GAP: LEDs_o = 0. When the gap counter expires:
  - pos = lfsr[3:0]; if pos equals the previous mole position, use pos+1 mod 16 instead;
  - LEDs_o = 1<<pos;
  - load the life counter;
  - go to UP.
- UP, whack: a whack is any bit change on switches_i[pos] against the previous-cycle sample. On a whack:
  - score+1;
  - pulse whack_o;
  - LEDs_o = 0;
  - go to GAP.
- UP, expiry: when the life counter reaches 0 on a tick:
  - miss+1;
  - LEDs_o = 0;
  - go to GAP.
- Changes on other switch bits are ignored.

LFSR:
- 16-bit Fibonacci, taps 16, 14, 13, 11.
- Advances every clock in every state, so player timing randomises the sequence.

Arithmetic:
- score saturates at 9999 (fits the 4-digit display).
- miss saturates at 255.
- time_left never underflows.

## Timing
- All outputs are registered. A response appears on the first clock edge after the causing input is sampled.
- Whack latency: the switch edge is sampled in cycle N. In cycle N+1, LEDs_o = 0, whack_o = 1 and score is updated.
- Simultaneous events:
  - Whack and expiry tick in the same cycle: the whack wins; miss is unchanged.
  - Whack on the same cycle as the final PLAY tick: the score is counted, then DONE.
- Final tick while UP: no miss is counted; LEDs_o clears and the state enters DONE together.
- Countdown duration is exactly 12 ticks from start to PLAY. PLAY lasts exactly 4*ROUND_SECS ticks.
- reset_i asserted mid-round: next edge returns everything to reset values, regardless of state. reset_i wins over start_i and tick_i.
- Switches held steady across phase changes produce no whack, because only edges count.

## Test plan
- Reset with random switches, then idle 100 cycles -> all outputs 0, state_o = 00, no whack_o.
- mode_i = 00 with start_i pulse -> stays IDLE. Then mode_i = 11 with start_i -> COUNTDOWN, time_left_o = 3,2,1. PLAY starts on tick 12 with time_left_o = ROUND_SECS.
- Easy mode, no switch activity, ROUND_SECS = 3 -> LEDs_o one-hot for 8 ticks, then 0 for 2 ticks, repeating. miss_o = 1 after the first mole expires. DONE after 12 PLAY ticks with score_o = 0.
- Toggle the lit switch 1 cycle after LEDs_o asserts -> next cycle LEDs_o = 0, whack_o = 1, score_o increments. Toggling an unlit switch -> no change.
- Toggle the lit switch on the same cycle as its expiry tick -> score_o +1, miss_o unchanged. Repeat on the final round tick -> score counted, state_o = 11.
- Assert reset_i mid-PLAY with score_o = 5 -> next cycle all outputs 0, state_o = 00. Also check: consecutive moles never share a position over 200 spawns, and score_o holds at 9999 when forced.
